// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce_gen switch-contact emulator.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          TMR_W     = 32;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running, used to randomise bounce spacing.
module lfsr16
    import bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/bounce_gen.sv
// Emulated bouncing switch: burst of glitch pairs, then a settle hold.
// Define BOUNCE_GEN_LFSR_EN for LFSR-randomised bounce intervals.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int          GLITCH_N   = 4,
    parameter logic [15:0] INTV_MASK  = 16'h03FF,
    parameter int          SETTLE_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       level,
    output logic       sw,
    output logic       busy,
    output logic       done_tick,
    output logic [7:0] edge_cnt
);

    localparam logic [7:0]       TOG_MAX   = 8'(2 * GLITCH_N);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC);

    state_t           state, state_n;
    logic             sw_n;
    logic [7:0]       edge_n;
    logic [7:0]       tog, tog_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [TMR_W-1:0] intv;

`ifdef BOUNCE_GEN_LFSR_EN
    logic [15:0] lfsr_q;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign intv = {16'd0, lfsr_q & INTV_MASK} + 32'd1;
`else
    assign intv = {16'd0, INTV_MASK} + 32'd1;
`endif

    assign busy      = (state != IDLE);
    assign done_tick = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sw       <= 1'b0;
            edge_cnt <= 8'd0;
            timer    <= '0;
            tog      <= 8'd0;
        end else begin
            state    <= state_n;
            sw       <= sw_n;
            edge_cnt <= edge_n;
            timer    <= timer_n;
            tog      <= tog_n;
        end
    end

    always_comb begin
        state_n = state;
        sw_n    = sw;
        edge_n  = edge_cnt;
        timer_n = timer;
        tog_n   = tog;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (level != sw) begin
                        sw_n   = level;
                        edge_n = 8'd1;
                        tog_n  = 8'd0;
                        if (GLITCH_N == 0) begin
                            state_n = SETTLE;
                            timer_n = SETTLE_LD;
                        end else begin
                            state_n = BOUNCE;
                            timer_n = intv;
                        end
                    end else begin
                        edge_n  = 8'd0;
                        state_n = DONE;
                    end
                end
            end
            BOUNCE: begin
                if (timer <= 32'd1) begin
                    sw_n   = ~sw;
                    edge_n = sat_inc(edge_cnt);
                    tog_n  = tog + 8'd1;
                    if (tog_n == TOG_MAX) begin
                        state_n = SETTLE;
                        timer_n = SETTLE_LD;
                    end else begin
                        timer_n = intv;
                    end
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
            SETTLE: begin
                if (timer == '0) begin
                    state_n = DONE;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: directed bursts, ignore, reset abort.
module tb_bounce_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, level_a = 1'b0;
    logic       start_b = 1'b0, level_b = 1'b0;
    logic       start_c = 1'b0, level_c = 1'b0;
    logic       sw_a, busy_a, done_a;
    logic       sw_b, busy_b, done_b;
    logic       sw_c, busy_c, done_c;
    logic [7:0] ec_a, ec_b, ec_c;

    always #5 clk = ~clk;

    bounce_gen #(.GLITCH_N(2), .INTV_MASK(16'h0003), .SETTLE_CYC(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .level(level_a),
        .sw(sw_a), .busy(busy_a), .done_tick(done_a), .edge_cnt(ec_a)
    );

    bounce_gen #(.GLITCH_N(0), .INTV_MASK(16'h0003), .SETTLE_CYC(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .level(level_b),
        .sw(sw_b), .busy(busy_b), .done_tick(done_b), .edge_cnt(ec_b)
    );

    bounce_gen #(.GLITCH_N(4), .INTV_MASK(16'h000F), .SETTLE_CYC(8)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .level(level_c),
        .sw(sw_c), .busy(busy_c), .done_tick(done_c), .edge_cnt(ec_c)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int kind;
        int t;
        int v;
    } ev_t;

    ev_t  sbq[$];
    bit   sb_en = 1'b0;
    logic prev_a = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input int t, input int v);
        ev_t e;
        e.kind = k;
        e.t = t;
        e.v = v;
        sbq.push_back(e);
    endtask

    // Burst on dut_a: edge at 0, toggles every 4 cycles, done after settle.
    task automatic push_burst(input int t0, input int lvl);
        push(0, t0, lvl);
        for (int i = 1; i <= 4; i++)
            push(0, t0 + 4 * i, (i % 2 == 1) ? 1 - lvl : lvl);
        push(1, t0 + 25, 5);
    endtask

    task automatic sb_cmp(input int k, input int v);
        ev_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got kind=%0d v=%0d t=%0d want none",
                     k, v, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.t != cyc || e.v != v) begin
                bad++;
                $display("FAIL sb_event: got kind=%0d t=%0d v=%0d want kind=%0d t=%0d v=%0d",
                         k, cyc, v, e.kind, e.t, e.v);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            if (sw_a !== prev_a) sb_cmp(0, int'(sw_a));
            if (done_a) sb_cmp(1, int'(ec_a));
            prev_a = sw_a;
        end
    end

    task automatic go_a(input logic lvl);
        level_a = lvl;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int   t0, t1, dt, nd, edges, last, iv, bad_iv;
        bit   moved, got_done;
        logic prev;

        repeat (3) @(negedge clk);
        chk("rst_sw", int'(sw_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_ec", int'(ec_a), 0);
        chk("rst_sw_c", int'(sw_c), 0);
        reset = 1'b0;
        @(negedge clk);

`ifndef BOUNCE_GEN_LFSR_EN
        prev_a = sw_a;
        sb_en = 1'b1;

        t0 = cyc + 1;
        push(1, t0, 0);
        go_a(1'b0);
        wait_until(t0 + 3);
        chk("same_sw", int'(sw_a), 0);
        chk("same_ec", int'(ec_a), 0);
        chk("same_busy", int'(busy_a), 0);

        t0 = cyc + 1;
        push_burst(t0, 1);
        go_a(1'b1);
        wait_until(t0 + 10);
        chk("main_busy", int'(busy_a), 1);
        wait_until(t0 + 30);
        chk("main_sw", int'(sw_a), 1);
        chk("main_ec", int'(ec_a), 5);
        chk("main_idle", int'(busy_a), 0);

        t0 = cyc + 1;
        push_burst(t0, 0);
        go_a(1'b0);
        wait_until(t0 + 5);
        level_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        level_a = 1'b0;
        wait_until(t0 + 30);
        chk("ign_sw", int'(sw_a), 0);
        chk("ign_ec", int'(ec_a), 5);

        t0 = cyc + 1;
        push(0, t0, 1);
        push(0, t0 + 4, 0);
        go_a(1'b1);
        wait_until(t0 + 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_sw", int'(sw_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        t1 = cyc + 1;
        push_burst(t1, 1);
        go_a(1'b1);
        wait_until(t1 + 30);
        chk("restart_sw", int'(sw_a), 1);
        chk("restart_ec", int'(ec_a), 5);
        chk("sb_drain", sbq.size(), 0);
        sb_en = 1'b0;
`endif

        t0 = cyc + 1;
        level_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("g0_sw", int'(sw_b), 1);
        chk("g0_busy", int'(busy_b), 1);
        dt = -1;
        nd = 0;
        moved = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sw_b !== 1'b1) moved = 1'b1;
            if (done_b) begin
                nd++;
                dt = cyc - t0;
                chk("g0_ec", int'(ec_b), 1);
            end
        end
        chk("g0_done_t", dt, 9);
        chk("g0_done_n", nd, 1);
        chk("g0_stable", int'(moved), 0);

        t0 = cyc + 1;
        level_c = 1'b1;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        chk("lf_first", int'(sw_c), 1);
        edges = 1;
        last = t0;
        prev = 1'b1;
        bad_iv = 0;
        got_done = 1'b0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            @(negedge clk);
            if (sw_c !== prev) begin
                iv = cyc - last;
`ifdef BOUNCE_GEN_LFSR_EN
                if (iv < 1 || iv > 16) bad_iv++;
`else
                if (iv != 16) bad_iv++;
`endif
                last = cyc;
                prev = sw_c;
                edges++;
            end
            if (done_c) got_done = 1'b1;
        end
        chk("lf_done", int'(got_done), 1);
        chk("lf_edges", edges, 9);
        chk("lf_ec", int'(ec_c), 9);
        chk("lf_sw", int'(sw_c), 1);
        chk("lf_intv", bad_iv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter GLITCH_N, default 4, meaning bounce pulse pairs emitted before settling; legal range 0..127.
REQ-002 SHALL have parameter INTV_MASK, default 16'h03FF, meaning mask for the bounce interval; must be 2^k-1.
REQ-003 SHALL have parameter SETTLE_CYC, default 50000, meaning stable hold cycles after the last bounce; legal minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a transition of sw to level; sampled only in IDLE.
REQ-007 SHALL have port level, input, 1 bit: target settled level, sampled with start.
REQ-008 SHALL have port sw, output, 1 bit: emulated bouncing switch contact, registered.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done_tick, output, 1 bit: one-cycle pulse when a request completes.
REQ-011 SHALL have port edge_cnt, output, 8 bits: sw transitions emitted since the last accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, BOUNCE, SETTLE, DONE.
REQ-013 SHALL, in IDLE with start=1 and level!=sw, on that edge: set sw to level, clear edge_cnt then add 1, load timer with interval, clear toggle count, go to BOUNCE (GLITCH_N=0: go to SETTLE).
REQ-014 SHALL, in IDLE with start=1 and level==sw, emit no edge, clear edge_cnt, and go to DONE.
REQ-015 SHALL, in BOUNCE, decrement timer each cycle; on timer reaching 1, toggle sw, increment edge_cnt and toggle count, and reload timer.
REQ-016 SHALL leave BOUNCE for SETTLE after 2*GLITCH_N toggles, so sw ends at level and each burst has exactly 1+2*GLITCH_N edges.
REQ-017 SHALL hold sw constant for SETTLE_CYC cycles in SETTLE, then go to DONE.
REQ-018 SHALL assert done_tick only in DONE, for exactly one cycle, then return to IDLE.
REQ-019 SHALL ignore start whenever busy=1; no queuing.
REQ-020 SHALL make the sw change visible on the clock edge that samples start (first-edge latency: one cycle).
REQ-021 SHALL saturate edge_cnt at 8'hFF.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, set state IDLE, sw=0, busy=0, done_tick=0, edge_cnt=0, timer=0, and LFSR=16'hACE1.
REQ-023 SHALL, on reset during BOUNCE or SETTLE, abort the burst, with no done_tick for the aborted request.

Configuration
REQ-024 SHALL use macro BOUNCE_GEN_LFSR_EN.
REQ-025 SHALL, when the macro is defined, use interval 1+(lfsr & INTV_MASK), range 1..INTV_MASK+1.
REQ-026 SHALL define the LFSR as 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle, sampled at each timer load.
REQ-027 SHALL, when the macro is undefined, use a fixed interval of INTV_MASK+1 and instantiate no LFSR logic.

Structure
REQ-028 SHALL place the state encoding, LFSR seed 16'hACE1, and tap constants in shared package bounce_gen_pkg.
REQ-029 SHALL implement the LFSR as sub-module lfsr16, with inputs clk, reset and output 16-bit q, instantiated only under BOUNCE_GEN_LFSR_EN.

Verification
REQ-030 SHALL check: macro off, GLITCH_N=2, INTV_MASK=3, SETTLE_CYC=8; start=1, level=1 from sw=0 -> sw 0→1 at cycle 0, toggles at cycles 4, 8, 12, 16; sw=1 from 16; done_tick at 25; edge_cnt=5.
REQ-031 SHALL check: start=1, level=0 with sw already 0 -> no sw change, edge_cnt=0, done_tick on the next cycle.
REQ-032 SHALL check: start pulsed during BOUNCE -> ignored; edge_cnt still reaches 5; exactly one done_tick.
REQ-033 SHALL check: reset asserted at cycle 6 of a burst -> sw=0, busy=0 next cycle; no done_tick; a new start is accepted immediately.
REQ-034 SHALL check: macro on, GLITCH_N=4, INTV_MASK=15 -> every sw interval within 1..16 cycles; edge_cnt=9; final sw=level.
REQ-035 SHALL check: GLITCH_N=0 -> a single edge, then SETTLE, then done_tick; edge_cnt=1.
